// File: rtl/ll_fifo_pkg.sv
// Shared constants and helpers for the linked-list FIFO drain path.
package ll_fifo_pkg;

  localparam int unsigned DRAIN_CNT_W = 16;

  // A select field needs at least one bit even for a single queue.
  function automatic int unsigned sel_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ll_fifo_rr_drain_if.sv
// Bundle between the round-robin drain, the shared FIFO and the downstream stream.
interface ll_fifo_rr_drain_if
  import ll_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned NUM_FIFOS = 2,
  parameter int unsigned SEL_WIDTH = sel_width(NUM_FIFOS)
) ();

  logic [NUM_FIFOS-1:0]   empty;
  logic [NUM_FIFOS-1:0]   q_en;
  logic [WIDTH-1:0]       fifo_data;
  logic                   pop;
  logic [SEL_WIDTH-1:0]   pop_sel;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [SEL_WIDTH-1:0]   out_sel;
  logic [DRAIN_CNT_W-1:0] drained;

  modport master (
    input  empty, q_en, fifo_data, out_ready,
    output pop, pop_sel, out_valid, out_data, out_sel, drained
  );

  modport slave (
    output empty, q_en, fifo_data, out_ready,
    input  pop, pop_sel, out_valid, out_data, out_sel, drained
  );

endinterface

// File: rtl/ll_fifo_rr_drain_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_FIFOS = 2,
  parameter int unsigned SEL_WIDTH = 1
) (
  input  logic [NUM_FIFOS-1:0] req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [NUM_FIFOS-1:0] gnt,
  output logic [SEL_WIDTH-1:0] idx,
  output logic                 any
);

  always_comb begin
    int unsigned          pos;
    logic [SEL_WIDTH-1:0] p;
    gnt = '0;
    idx = ptr;
    any = 1'b0;
    pos = 0;
    p   = '0;
    for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
      // Explicit wrap so non-power-of-2 queue counts stay in range.
      pos = 32'(ptr) + k;
      if (pos >= NUM_FIFOS) pos = pos - NUM_FIFOS;
      p = SEL_WIDTH'(pos);
      if (!any && req[p]) begin
        any    = 1'b1;
        gnt[p] = 1'b1;
        idx    = p;
      end
    end
  end

endmodule

// File: rtl/ll_fifo_rr_drain.sv
// Round-robin drain of a shared linked-list FIFO into a 2-entry tagged output stream.
module ll_fifo_rr_drain
  import ll_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned NUM_FIFOS = 2,
  parameter int unsigned SEL_WIDTH = sel_width(NUM_FIFOS)
) (
  input logic                clk,
  input logic                rst,
  ll_fifo_rr_drain_if.master bus
);

  typedef struct packed {
    logic [SEL_WIDTH-1:0] sel;
    logic [WIDTH-1:0]     data;
  } entry_t;

  logic [NUM_FIFOS-1:0]   elig;
  logic [NUM_FIFOS-1:0]   gnt;
  logic [SEL_WIDTH-1:0]   g;
  logic                   any;
  logic [SEL_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  entry_t                 buf_q [2];
  entry_t                 buf_d [2];
  logic [1:0]             occ_q, occ_d, occ_mid;
  logic [DRAIN_CNT_W-1:0] drained_q, drained_d;
  logic                   deq, space, pop;
  logic                   unused_gnt;

  assign elig       = ~bus.empty & bus.q_en;
  assign unused_gnt = ^gnt;

  rr_arbiter #(
    .NUM_FIFOS (NUM_FIFOS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arb (
    .req (elig),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (g),
    .any (any)
  );

  assign bus.out_valid = (occ_q != 2'd0);
  assign deq           = bus.out_valid & bus.out_ready;
  assign space         = (occ_q < 2'd2) | deq;
  // Gating with rst keeps the shared FIFO untouched while both are in reset.
  assign pop           = rst & space & any;

  assign bus.pop      = pop;
  assign bus.pop_sel  = pop ? g : rr_ptr_q;
  assign bus.out_data = buf_q[0].data;
  assign bus.out_sel  = buf_q[0].sel;
  assign bus.drained  = drained_q;

  always_comb begin
    buf_d   = buf_q;
    occ_mid = occ_q - {1'b0, deq};
    if (deq) buf_d[0] = buf_q[1];
    // New word lands behind whatever survives this cycle's dequeue.
    if (pop) buf_d[occ_mid[0]] = '{sel: g, data: bus.fifo_data};
    occ_d = occ_mid + {1'b0, pop};

    rr_ptr_d = rr_ptr_q;
    if (pop) rr_ptr_d = (g == SEL_WIDTH'(NUM_FIFOS - 1)) ? '0 : g + 1'b1;

    drained_d = drained_q;
    if (deq && (drained_q != '1)) drained_d = drained_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q     <= '0;
      rr_ptr_q  <= '0;
      drained_q <= '0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
    end else begin
      occ_q     <= occ_d;
      rr_ptr_q  <= rr_ptr_d;
      drained_q <= drained_d;
      buf_q     <= buf_d;
    end
  end

  a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst)
    pop |-> !bus.empty[bus.pop_sel]);
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst) occ_q <= 2'd2);
  a_no_deq_empty: assert property (@(posedge clk) disable iff (!rst)
    !(!bus.out_valid && deq));

endmodule

// File: tb/tb_ll_fifo_rr_drain.sv
// Bench for ll_fifo_rr_drain: directed vector table, random stream and counter saturation,
// all checked against a queue-based reference model.
module tb_ll_fifo_rr_drain;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned NUM_FIFOS = 2;
  localparam int unsigned SEL_WIDTH = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ll_fifo_rr_drain_if #(
    .WIDTH     (WIDTH),
    .NUM_FIFOS (NUM_FIFOS),
    .SEL_WIDTH (SEL_WIDTH)
  ) bus ();

  ll_fifo_rr_drain #(
    .WIDTH     (WIDTH),
    .NUM_FIFOS (NUM_FIFOS),
    .SEL_WIDTH (SEL_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       r;
    logic [1:0] e;
    logic [1:0] en;
    logic       rdy;
    logic [3:0] d;
    logic       x_pop;
    logic       x_sel;
    logic       x_valid;
  } vec_t;

  typedef struct {
    int         sel;
    logic [3:0] data;
  } ent_t;

  vec_t vecs[$];
  ent_t m_buf[$];
  int   m_ptr     = 0;
  int   m_drained = 0;
  int   n_checks  = 0;
  int   n_pass    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle, compare against the model mid-cycle, then advance the model.
  task automatic step(input logic r, input logic [1:0] e, input logic [1:0] en,
                      input logic rdy, input logic [3:0] d, input bit has_exp,
                      input logic x_pop, input logic x_sel, input logic x_valid);
    bit any, space, m_deq, m_pop;
    int g, m_sel, j;
    rst           = r;
    bus.empty     = e;
    bus.q_en      = en;
    bus.out_ready = rdy;
    bus.fifo_data = d;
    @(negedge clk);
    any = 1'b0;
    g   = m_ptr;
    for (int k = 0; k < int'(NUM_FIFOS); k++) begin
      j = (m_ptr + k) % int'(NUM_FIFOS);
      if (!any && (((e >> j) & 2'b01) == 2'b00) && (((en >> j) & 2'b01) != 2'b00)) begin
        any = 1'b1;
        g   = j;
      end
    end
    m_deq = (m_buf.size() > 0) && rdy;
    space = (m_buf.size() < 2) || m_deq;
    m_pop = r && any && space;
    m_sel = m_pop ? g : m_ptr;
    chk("pop", 32'(bus.pop), 32'(m_pop));
    chk("pop_sel", 32'(bus.pop_sel), 32'(m_sel));
    chk("out_valid", 32'(bus.out_valid), 32'(m_buf.size() > 0));
    chk("drained", 32'(bus.drained), 32'(m_drained));
    if (m_buf.size() > 0) begin
      chk("out_sel", 32'(bus.out_sel), 32'(m_buf[0].sel));
      chk("out_data", 32'(bus.out_data), 32'(m_buf[0].data));
    end
    if (has_exp) begin
      chk("vec_pop", 32'(bus.pop), 32'(x_pop));
      chk("vec_pop_sel", 32'(bus.pop_sel), 32'(x_sel));
      chk("vec_out_valid", 32'(bus.out_valid), 32'(x_valid));
    end
    if (!r) begin
      m_buf.delete();
      m_ptr     = 0;
      m_drained = 0;
    end else begin
      if (m_deq) begin
        void'(m_buf.pop_front());
        if (m_drained < 65535) m_drained++;
      end
      if (m_pop) begin
        m_buf.push_back('{g, d});
        m_ptr = (g + 1) % int'(NUM_FIFOS);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {rst, empty, q_en, ready, data, exp pop, exp pop_sel, exp out_valid}
    vecs.push_back('{1'b0, 2'b00, 2'b11, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0}); // in reset
    vecs.push_back('{1'b1, 2'b00, 2'b11, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0}); // first active
    vecs.push_back('{1'b1, 2'b00, 2'b11, 1'b1, 4'h2, 1'b1, 1'b1, 1'b1}); // fairness
    vecs.push_back('{1'b1, 2'b00, 2'b11, 1'b1, 4'h3, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 2'b00, 2'b11, 1'b1, 4'h4, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 2'b00, 2'b11, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 2'b00, 2'b11, 1'b0, 4'h6, 1'b1, 1'b1, 1'b1}); // fill to 2
    vecs.push_back('{1'b1, 2'b00, 2'b11, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1}); // backpressure
    vecs.push_back('{1'b1, 2'b00, 2'b11, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 2'b00, 2'b11, 1'b1, 4'h8, 1'b1, 1'b0, 1'b1}); // deq+pop at 2
    vecs.push_back('{1'b1, 2'b00, 2'b11, 1'b0, 4'h8, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 2'b11, 2'b11, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1}); // drain
    vecs.push_back('{1'b1, 2'b11, 2'b11, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 2'b01, 2'b01, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0}); // masked
    vecs.push_back('{1'b1, 2'b01, 2'b11, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0}); // unmask
    vecs.push_back('{1'b1, 2'b10, 2'b11, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1}); // last word q0
    vecs.push_back('{1'b1, 2'b11, 2'b11, 1'b0, 4'hB, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 2'b11, 2'b11, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 2'b00, 2'b11, 1'b0, 4'hC, 1'b1, 1'b1, 1'b0}); // refill
    vecs.push_back('{1'b1, 2'b00, 2'b11, 1'b0, 4'hD, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 2'b00, 2'b11, 1'b0, 4'hD, 1'b0, 1'b1, 1'b1}); // mid reset
    vecs.push_back('{1'b1, 2'b00, 2'b11, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0}); // restart q0
    vecs.push_back('{1'b1, 2'b00, 2'b11, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1});

    // Unchecked first reset cycle: state is unknown until the first edge.
    rst           = 1'b0;
    bus.empty     = 2'b00;
    bus.q_en      = 2'b11;
    bus.out_ready = 1'b0;
    bus.fifo_data = 4'h0;
    @(posedge clk);
    #1;

    foreach (vecs[i])
      step(vecs[i].r, vecs[i].e, vecs[i].en, vecs[i].rdy, vecs[i].d, 1'b1,
           vecs[i].x_pop, vecs[i].x_sel, vecs[i].x_valid);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 59) != 0), 2'($urandom), 2'($urandom), 1'($urandom),
           4'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);

    // Continuous flow long enough to saturate the drained counter.
    for (int i = 0; i < 65600; i++)
      step(1'b1, 2'b00, 2'b11, 1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drained_saturated", 32'(bus.drained), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
